// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, sticky status/overrun
// flags held until the register-read path acknowledges with rx_clear.
module uart_rx_core #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_clear,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_status,
   output logic       rx_overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_rx_core: CLK_FREQ/(BAUD*16) must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t          state, state_nxt;
   logic            rx_sync1, rx_s, rx_d;
   logic [CW-1:0]   tick_cnt;
   logic [3:0]      sample_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;
   logic            tick;
   logic            start_ok, bit_done, stop_good, stop_bad;

   assign tick = (tick_cnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync1 <= 1'b1;
         rx_s     <= 1'b1;
         rx_d     <= 1'b1;
      end else begin
         rx_sync1 <= rx;
         rx_s     <= rx_sync1;
         rx_d     <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      bit_done  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         S_IDLE: begin
            // Edge-only detection: a line stuck low never starts a frame.
            if (rx_d && !rx_s) state_nxt = S_START;
         end
         S_START: begin
            if (tick && sample_cnt == 4'd7) begin
               if (!rx_s) begin
                  start_ok  = 1'b1;
                  state_nxt = S_DATA;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick && sample_cnt == 4'd15) begin
               bit_done = 1'b1;
               if (bit_idx == 3'd7) state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && sample_cnt == 4'd15) begin
               state_nxt = S_IDLE;
               if (rx_s) stop_good = 1'b1;
               else      stop_bad  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counters sit at zero in IDLE, so start detection needs no explicit clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt   <= '0;
         sample_cnt <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
      end else begin
         if (state == S_IDLE || tick) tick_cnt <= '0;
         else                         tick_cnt <= tick_cnt + CW'(1);

         if (state == S_IDLE || start_ok) sample_cnt <= '0;
         else if (tick)                   sample_cnt <= sample_cnt + 4'd1;

         if (start_ok)      bit_idx <= '0;
         else if (bit_done) bit_idx <= bit_idx + 3'd1;

         if (bit_done) shift_reg <= {rx_s, shift_reg[7:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_status  <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_valid <= stop_good;
         busy     <= (state_nxt != S_IDLE);
         if (stop_good) begin
            rx_data    <= shift_reg;
            rx_status  <= 1'b1;
            frame_err  <= 1'b0;
            // A coincident acknowledge consumes the old byte, so no overrun.
            rx_overrun <= rx_clear ? 1'b0 : (rx_overrun | rx_status);
         end else if (rx_clear) begin
            rx_status  <= 1'b0;
            rx_overrun <= 1'b0;
         end
         if (stop_bad) frame_err <= 1'b1;
      end
   end

endmodule
